lcd_cmd_issuer: RTL and testbench

//   Host-side command initiator for the LCD controller. Buffers commands from an

---
 rtl/lcd_pkg.sv | 36 +++
 rtl/lcd_cmd_fifo.sv | 79 +++++++
 rtl/lcd_cmd_issuer.sv | 179 +++++++++++++++++
 tb/tb_lcd_cmd_issuer.sv | 355 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_pkg.sv
// Shared definitions for the LCD command issuer: controller command codes,
// default widths, the issuer FSM state type and the checksum helper.
package lcd_pkg;

    localparam int unsigned CMD_W_DEF  = 4;
    localparam int unsigned DATA_W_DEF = 8;
    localparam int unsigned ADDR_W_DEF = 6;

    // Controller command codes; only CMD_WRITE changes issuer behaviour.
    typedef enum logic [3:0] {
        CMD_WRITE      = 4'd0,
        CMD_SHIFT_UP   = 4'd1,
        CMD_SHIFT_DOWN = 4'd2,
        CMD_SHIFT_LEFT = 4'd3,
        CMD_SHIFT_RGT  = 4'd4,
        CMD_AVERAGE    = 4'd5,
        CMD_MIRROR_X   = 4'd6,
        CMD_MIRROR_Y   = 4'd7
    } lcd_cmd_e;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ACK   = 3'd1,
        RUN   = 3'd2,
        WRITE = 3'd3,
        FIN   = 3'd4,
        ERR   = 3'd5
    } issuer_state_e;

    // Image checksum step: plain 16-bit add, wrapping on overflow.
    function automatic logic [15:0] csum_add(input logic [15:0] acc,
                                             input logic [15:0] addend);
        return acc + addend;
    endfunction

endpackage

// File: rtl/lcd_cmd_fifo.sv
// Small synchronous command FIFO. The head entry is read straight from the
// storage registers, so a freshly pushed command is visible one cycle later.
module lcd_cmd_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count_q == CNT_FULL);
    assign empty   = (count_q == {CNT_W{1'b0}});
    assign head    = mem_q[rd_ptr_q];
    // A push at full is refused even if a pop happens in the same cycle.
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;

    // Next-state for storage, pointers and occupancy.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + PTR_ONE;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    // FIFO registers; reset drops all buffered commands.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= {WIDTH{1'b0}};
            end
            wr_ptr_q <= {PTR_W{1'b0}};
            rd_ptr_q <= {PTR_W{1'b0}};
            count_q  <= {CNT_W{1'b0}};
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/lcd_cmd_issuer.sv
// Host-side LCD command issuer: buffers upstream commands, strobes them to the
// controller while it is idle, tracks the busy handshake with a timeout, and
// after the write command accumulates a checksum and beat count of the image.
module lcd_cmd_issuer
    import lcd_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned CMD_W      = CMD_W_DEF,
    parameter int unsigned DATA_W     = DATA_W_DEF,
    parameter int unsigned ADDR_W     = ADDR_W_DEF,
    parameter int unsigned ACK_TMO    = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [CMD_W-1:0]  up_cmd,
    input  logic              up_valid,
    output logic              up_ready,
    output logic [CMD_W-1:0]  cmd,
    output logic              cmd_valid,
    input  logic              busy,
    input  logic              done,
    input  logic              IRAM_valid,
    input  logic [DATA_W-1:0] IRAM_D,
    input  logic [ADDR_W-1:0] IRAM_A,
    output logic              finished,
    output logic [15:0]       checksum,
    output logic [ADDR_W:0]   beat_cnt,
    output logic              err_tmo
);

    localparam int unsigned TMR_W  = $clog2(ACK_TMO + 1);
    localparam int unsigned BEAT_W = ADDR_W + 1;
    localparam logic [TMR_W-1:0]  TMR_LAST = TMR_W'(ACK_TMO - 1);
    localparam logic [TMR_W-1:0]  TMR_ONE  = TMR_W'(1);
    localparam logic [BEAT_W-1:0] BEAT_MAX = BEAT_W'(2 ** ADDR_W);
    localparam logic [BEAT_W-1:0] BEAT_ONE = BEAT_W'(1);
    localparam logic [CMD_W-1:0]  WR_CODE  = CMD_W'(CMD_WRITE);

    issuer_state_e     state_q, state_d;
    logic [CMD_W-1:0]  cmd_q, cmd_d;
    logic              cmd_valid_q, cmd_valid_d;
    logic              finished_q, finished_d;
    logic [15:0]       checksum_q, checksum_d;
    logic [BEAT_W-1:0] beat_cnt_q, beat_cnt_d;
    logic              err_tmo_q, err_tmo_d;
    logic [TMR_W-1:0]  timer_q, timer_d;

    logic              fifo_pop;
    logic              fifo_full;
    logic              fifo_empty;
    logic [CMD_W-1:0]  fifo_head;
    logic              unused_addr;

    // The write address is not needed: every valid beat counts, in any order.
    assign unused_addr = ^IRAM_A;

    assign up_ready = ~fifo_full;

    lcd_cmd_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (CMD_W)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (reset),
        .push      (up_valid & ~fifo_full),
        .push_data (up_cmd),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Issue/handshake FSM next-state plus accumulator updates.
    always_comb begin
        state_d     = state_q;
        cmd_d       = cmd_q;
        cmd_valid_d = 1'b0;
        finished_d  = finished_q;
        checksum_d  = checksum_q;
        beat_cnt_d  = beat_cnt_q;
        err_tmo_d   = err_tmo_q;
        timer_d     = timer_q;
        fifo_pop    = 1'b0;
        case (state_q)
            IDLE: begin
                // Busy here may be the controller's own start-up load: wait forever.
                if (!fifo_empty && !busy) begin
                    fifo_pop    = 1'b1;
                    cmd_d       = fifo_head;
                    cmd_valid_d = 1'b1;
                    timer_d     = {TMR_W{1'b0}};
                    state_d     = ACK;
                end else begin
                    state_d = IDLE;
                end
            end
            ACK: begin
                if (busy) begin
                    state_d = RUN;
                end else if (timer_q == TMR_LAST) begin
                    err_tmo_d = 1'b1;
                    state_d   = ERR;
                end else begin
                    timer_d = timer_q + TMR_ONE;
                end
            end
            RUN: begin
                // The write command streams pixels while busy is still high.
                if (cmd_q == WR_CODE) begin
                    state_d = WRITE;
                end else if (!busy) begin
                    state_d = IDLE;
                end else begin
                    state_d = RUN;
                end
            end
            WRITE: begin
                if (IRAM_valid) begin
                    checksum_d = csum_add(checksum_q, 16'(IRAM_D));
                    if (beat_cnt_q != BEAT_MAX) begin
                        beat_cnt_d = beat_cnt_q + BEAT_ONE;
                    end else begin
                        beat_cnt_d = BEAT_MAX;
                    end
                end else begin
                    checksum_d = checksum_q;
                end
                if (done) begin
                    finished_d = 1'b1;
                    state_d    = FIN;
                end else begin
                    state_d = WRITE;
                end
            end
            FIN: begin
                finished_d = 1'b1;
                state_d    = FIN;
            end
            ERR: begin
                err_tmo_d = 1'b1;
                state_d   = ERR;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // FSM state and all registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            cmd_q       <= {CMD_W{1'b0}};
            cmd_valid_q <= 1'b0;
            finished_q  <= 1'b0;
            checksum_q  <= 16'd0;
            beat_cnt_q  <= {BEAT_W{1'b0}};
            err_tmo_q   <= 1'b0;
            timer_q     <= {TMR_W{1'b0}};
        end else begin
            state_q     <= state_d;
            cmd_q       <= cmd_d;
            cmd_valid_q <= cmd_valid_d;
            finished_q  <= finished_d;
            checksum_q  <= checksum_d;
            beat_cnt_q  <= beat_cnt_d;
            err_tmo_q   <= err_tmo_d;
            timer_q     <= timer_d;
        end
    end

    assign cmd       = cmd_q;
    assign cmd_valid = cmd_valid_q;
    assign finished  = finished_q;
    assign checksum  = checksum_q;
    assign beat_cnt  = beat_cnt_q;
    assign err_tmo   = err_tmo_q;

endmodule

// File: tb/tb_lcd_cmd_issuer.sv
// Self-checking bench for lcd_cmd_issuer: random command streams, a busy
// responder, random image beats, and a transaction-level reference model
// (expected issue order, arithmetic checksum, saturating beat count).
module tb_lcd_cmd_issuer;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  up_cmd;
    logic        up_valid;
    logic        up_ready;
    logic [3:0]  cmd;
    logic        cmd_valid;
    logic        busy;
    logic        force_busy;
    logic        resp_busy;
    logic        done;
    logic        IRAM_valid;
    logic [7:0]  IRAM_D;
    logic [5:0]  IRAM_A;
    logic        finished;
    logic [15:0] checksum;
    logic [6:0]  beat_cnt;
    logic        err_tmo;

    int tests = 0;
    int fails = 0;

    // Responder knobs (written by the main sequence only).
    bit resp_en   = 1'b0;
    int resp_dmax = 0;
    int resp_hmin = 1;
    int resp_hmax = 1;

    // Monitor results (written by the monitor only).
    logic [3:0] obs_q[$];
    int n_strobes = 0;
    int viol_busy = 0;
    int viol_b2b  = 0;
    int cyc       = 0;
    int last_strobe_cyc = 0;
    bit prev_valid = 1'b0;

    // Reference model state (main sequence only).
    logic [3:0] exp_q[$];
    int base = 0;

    always #5 clk = ~clk;
    assign busy = force_busy | resp_busy;

    lcd_cmd_issuer #(
        .FIFO_DEPTH (4),
        .CMD_W      (4),
        .DATA_W     (8),
        .ADDR_W     (6),
        .ACK_TMO    (15)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .up_cmd     (up_cmd),
        .up_valid   (up_valid),
        .up_ready   (up_ready),
        .cmd        (cmd),
        .cmd_valid  (cmd_valid),
        .busy       (busy),
        .done       (done),
        .IRAM_valid (IRAM_valid),
        .IRAM_D     (IRAM_D),
        .IRAM_A     (IRAM_A),
        .finished   (finished),
        .checksum   (checksum),
        .beat_cnt   (beat_cnt),
        .err_tmo    (err_tmo)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Controller stand-in: raises busy 1+d cycles after each strobe, holds it h cycles.
    initial begin
        int d;
        int h;
        resp_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (resp_en && cmd_valid === 1'b1) begin
                d = int'($urandom_range(resp_dmax, 0));
                h = int'($urandom_range(resp_hmax, resp_hmin));
                repeat (1 + d) @(negedge clk);
                resp_busy = 1'b1;
                repeat (h) @(negedge clk);
                resp_busy = 1'b0;
            end
        end
    end

    // Strobe monitor: records issued commands and protocol violations.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (cmd_valid === 1'b1) begin
                if (busy !== 1'b0) viol_busy++;
                if (prev_valid) viol_b2b++;
                obs_q.push_back(cmd);
                n_strobes++;
                last_strobe_cyc = cyc;
            end
            prev_valid = (cmd_valid === 1'b1);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    task automatic check_reset_outputs(input string where);
        check({where, "_cmd"},       32'(cmd),       32'd0);
        check({where, "_cmd_valid"}, 32'(cmd_valid), 32'd0);
        check({where, "_finished"},  32'(finished),  32'd0);
        check({where, "_checksum"},  32'(checksum),  32'd0);
        check({where, "_beat_cnt"},  32'(beat_cnt),  32'd0);
        check({where, "_err_tmo"},   32'(err_tmo),   32'd0);
        check({where, "_up_ready"},  32'(up_ready),  32'd1);
    endtask

    task automatic apply_reset();
        resp_en = 1'b0;
        @(negedge clk);
        reset      = 1'b0;
        up_valid   = 1'b0;
        up_cmd     = 4'd0;
        force_busy = 1'b0;
        done       = 1'b0;
        IRAM_valid = 1'b0;
        IRAM_D     = 8'd0;
        IRAM_A     = 6'd0;
        repeat (12) @(negedge clk);
        reset = 1'b1;
        exp_q.delete();
        base = n_strobes;
    endtask

    task automatic push_cmd(input logic [3:0] c, input int maxwait, output bit ok);
        int waited;
        waited = 0;
        @(negedge clk);
        up_cmd   = c;
        up_valid = 1'b1;
        while (!up_ready && waited < maxwait) begin
            @(negedge clk);
            waited++;
        end
        ok = up_ready;
        @(negedge clk);
        up_valid = 1'b0;
    endtask

    task automatic wait_strobes(input int n, input int budget, input string tag);
        int t;
        t = 0;
        while ((n_strobes - base) < n && t < budget) begin
            @(posedge clk);
            #2;
            t++;
        end
        check({tag, "_strobe_wait"}, 32'((n_strobes - base) >= n), 32'd1);
    endtask

    task automatic compare_issued(input string tag);
        check({tag, "_issue_count"}, 32'(obs_q.size() - base), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            if (base + i < obs_q.size()) begin
                check($sformatf("%s_issue%0d", tag, i), 32'(obs_q[base + i]), 32'(exp_q[i]));
            end
        end
    endtask

    task automatic drive_beats(input int n, input int gap_max, input bit ramp, input bit fin,
                               output int sum, output int cnt);
        int g;
        sum = 0;
        for (int a = 0; a < n; a++) begin
            g = int'($urandom_range(gap_max, 0));
            repeat (g) begin
                @(negedge clk);
                IRAM_valid = 1'b0;
                done       = 1'b0;
            end
            @(negedge clk);
            IRAM_valid = 1'b1;
            IRAM_A     = 6'(a);
            IRAM_D     = ramp ? 8'(a + 1) : 8'($urandom_range(255, 0));
            done       = fin && (a == n - 1);
            sum        = (sum + int'(IRAM_D)) % 65536;
        end
        @(negedge clk);
        IRAM_valid = 1'b0;
        done       = 1'b0;
        cnt = (n > 64) ? 64 : n;
    endtask

    initial begin
        bit ok;
        int acc;
        int sum;
        int cnt;
        int delta;
        int t;
        int k;
        int nb;
        logic [3:0] c;

        reset = 1'b0; up_valid = 1'b0; up_cmd = 4'd0; force_busy = 1'b0;
        done = 1'b0; IRAM_valid = 1'b0; IRAM_D = 8'd0; IRAM_A = 6'd0;
        repeat (3) @(negedge clk);
        check_reset_outputs("rst");
        reset = 1'b1;
        @(negedge clk);
        check("rst_release_up_ready", 32'(up_ready), 32'd1);

        // Busy held high in IDLE stalls issue with no timeout.
        resp_en = 1'b1; resp_dmax = 0; resp_hmin = 3; resp_hmax = 3;
        force_busy = 1'b1;
        push_cmd(4'd3, 5, ok);
        check("t1_push", 32'(ok), 32'd1);
        exp_q.push_back(4'd3);
        repeat (70) @(negedge clk);
        check("t1_stall", 32'(n_strobes - base), 32'd0);
        check("t1_no_tmo", 32'(err_tmo), 32'd0);
        force_busy = 1'b0;
        wait_strobes(1, 20, "t1");
        repeat (20) @(negedge clk);
        compare_issued("t1");
        check("t1_cmd_hold", 32'(cmd), 32'd3);

        // Commands 1,2,0 with a 1-cycle / 3-cycle responder, then a ramp image.
        push_cmd(4'd1, 50, ok); exp_q.push_back(4'd1);
        push_cmd(4'd2, 50, ok); exp_q.push_back(4'd2);
        push_cmd(4'd0, 50, ok); exp_q.push_back(4'd0);
        wait_strobes(4, 200, "t3");
        compare_issued("t3");
        repeat (10) @(negedge clk);
        check("t4_not_finished", 32'(finished), 32'd0);
        drive_beats(64, 0, 1'b1, 1'b1, sum, cnt);
        check("t4_checksum", 32'(checksum), 32'd2080);
        check("t4_beat_cnt", 32'(beat_cnt), 32'd64);
        check("t4_finished", 32'(finished), 32'd1);

        // FIN: beats ignored, FIFO fills to depth, nothing issues.
        drive_beats(5, 1, 1'b0, 1'b1, sum, cnt);
        check("fin_checksum_frozen", 32'(checksum), 32'd2080);
        check("fin_beat_frozen", 32'(beat_cnt), 32'd64);
        acc = 0;
        for (int i = 0; i < 5; i++) begin
            push_cmd(4'(i + 5), 2, ok);
            acc += int'(ok);
        end
        check("fin_accepted", 32'(acc), 32'd4);
        check("fin_up_ready", 32'(up_ready), 32'd0);
        repeat (10) @(negedge clk);
        check("fin_no_issue", 32'(n_strobes - base), 32'd4);

        // Ack timeout: busy never rises.
        apply_reset();
        acc = 0;
        for (int i = 0; i < 6; i++) begin
            push_cmd(4'(9 + i), 0, ok);
            acc += int'(ok);
        end
        exp_q.push_back(4'd9);
        check("t2_accepted", 32'(acc), 32'd5);
        check("t2_up_ready", 32'(up_ready), 32'd0);
        t = 0;
        while (err_tmo !== 1'b1 && t < 60) begin
            @(posedge clk);
            #2;
            t++;
        end
        delta = cyc - last_strobe_cyc;
        check("t2_err_tmo", 32'(err_tmo), 32'd1);
        check("t2_tmo_delay_ok", 32'(delta >= 15 && delta <= 16), 32'd1);
        repeat (30) @(negedge clk);
        compare_issued("t2");
        check("t2_err_sticky", 32'(err_tmo), 32'd1);
        check("t2_not_finished", 32'(finished), 32'd0);

        // Reset in the middle of a write drops everything, including the FIFO.
        apply_reset();
        resp_en = 1'b1; resp_dmax = 2; resp_hmin = 1; resp_hmax = 4;
        push_cmd(4'd0, 10, ok);
        exp_q.push_back(4'd0);
        wait_strobes(1, 50, "t5");
        repeat (10) @(negedge clk);
        drive_beats(20, 1, 1'b0, 1'b0, sum, cnt);
        check("t5_partial_sum", 32'(checksum), 32'(sum));
        check("t5_partial_cnt", 32'(beat_cnt), 32'(cnt));
        push_cmd(4'd7, 2, ok);
        check("t5_push_in_write", 32'(ok), 32'd1);
        push_cmd(4'd9, 2, ok);
        @(negedge clk);
        IRAM_valid = 1'b1;
        IRAM_D     = 8'd77;
        reset      = 1'b0;
        #1;
        check_reset_outputs("t5_rst");
        IRAM_valid = 1'b0;
        resp_en = 1'b0;
        repeat (12) @(negedge clk);
        reset = 1'b1;
        base = n_strobes;
        exp_q.delete();
        repeat (20) @(negedge clk);
        check("t5_fifo_empty", 32'(n_strobes - base), 32'd0);
        check("t5_up_ready", 32'(up_ready), 32'd1);

        // Random command streams followed by random images (saturating and not).
        for (int r = 0; r < 2; r++) begin
            apply_reset();
            resp_en = 1'b1; resp_dmax = 4; resp_hmin = 1; resp_hmax = 5;
            k = int'($urandom_range(6, 3));
            for (int i = 0; i < k; i++) begin
                c = 4'($urandom_range(15, 1));
                repeat ($urandom_range(3, 0)) @(negedge clk);
                push_cmd(c, 200, ok);
                check("rnd_push", 32'(ok), 32'd1);
                exp_q.push_back(c);
            end
            push_cmd(4'd0, 200, ok);
            exp_q.push_back(4'd0);
            wait_strobes(k + 1, 2000, "rnd");
            compare_issued("rnd");
            repeat (12) @(negedge clk);
            nb = (r == 0) ? int'($urandom_range(90, 65)) : int'($urandom_range(63, 1));
            drive_beats(nb, 2, 1'b0, 1'b1, sum, cnt);
            check("rnd_checksum", 32'(checksum), 32'(sum));
            check("rnd_beat_cnt", 32'(beat_cnt), 32'(cnt));
            check("rnd_finished", 32'(finished), 32'd1);
        end

        check("no_strobe_while_busy", 32'(viol_busy), 32'd0);
        check("no_back_to_back_strobe", 32'(viol_b2b), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
